// File: rtl/dft_pkg.sv
// Shared types and constants for the 32-point DFT sequencer slice.
package dft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD,
    DONE
  } seq_state_e;

  localparam int NUM_PHASES        = 4;
  localparam int SEL_W             = 2;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int DEF_HOLD_CYCLES   = 5;

endpackage

// File: rtl/dft32_seq_ctrl_if.sv
// Frame handshake and datapath control bundle for dft32_seq_ctrl.
// Optional macro DFT_SEQ_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface dft32_seq_ctrl_if
  import dft_pkg::*;
  ;

  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      SEL;
  logic [NUM_PHASES-1:0] enable;
  logic                  busy;
  logic                  frame_done;
`ifdef DFT_SEQ_FRAME_CNT_EN
  logic [15:0]           frame_cnt;
`endif

  // Sequencer side
  modport master (
    input  in_valid,
    output in_ready,
    output SEL,
    output enable,
    output busy,
`ifdef DFT_SEQ_FRAME_CNT_EN
    output frame_cnt,
`endif
    output frame_done
  );

  // Frame source / datapath side
  modport slave (
    output in_valid,
    input  in_ready,
    input  SEL,
    input  enable,
    input  busy,
`ifdef DFT_SEQ_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  frame_done
  );

endinterface

// File: rtl/dft_seq_down_cnt.sv
// Loadable down-counter with zero flag; shared by the settle and hold waits.
// Saturates at zero so a stray decrement can never wrap.
module dft_seq_down_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dft32_seq_ctrl.sv
// Sequencer for the 32-point DFT datapath: steps SEL through 0..3, waits
// SETTLE_CYCLES before each one-hot capture strobe, holds the register bank
// for HOLD_CYCLES, then pulses frame_done.
// Optional macro DFT_SEQ_FRAME_CNT_EN adds a wrapping 16-bit frame counter.
module dft32_seq_ctrl
  import dft_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = 4
) (
  input  logic             clk_100,
  input  logic             reset,
  dft32_seq_ctrl_if.master bus
);

  // With no settle time the sequencer goes straight from accept/capture to
  // the next capture, so the settle load value is only meaningful when > 0.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam seq_state_e       AFTER_CAP  = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
  localparam logic [SEL_W-1:0] LAST_PHASE = SEL_W'(NUM_PHASES - 1);

  seq_state_e       state, state_nxt;
  logic [SEL_W-1:0] phase, phase_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  dft_seq_down_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk_100),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State and phase registers
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state, phase advance and counter control
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          phase_nxt = '0;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
          state_nxt = AFTER_CAP;
        end
      end
      SETTLE: begin
        if (cnt_zero) state_nxt = CAPTURE;
        else          cnt_dec   = 1'b1;
      end
      CAPTURE: begin
        cnt_load = 1'b1;
        if (phase != LAST_PHASE) begin
          phase_nxt = phase + 1'b1;
          cnt_val   = SETTLE_LOAD;
          state_nxt = AFTER_CAP;
        end else begin
          cnt_val   = HOLD_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt_zero) state_nxt = DONE;
        else          cnt_dec   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state/phase only; nothing from in_valid
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.frame_done = (state == DONE);
    bus.enable     = '0;
    bus.SEL        = '0;
    case (state)
      SETTLE:    bus.SEL = phase;
      CAPTURE: begin
        bus.SEL    = phase;
        bus.enable = NUM_PHASES'(1) << phase;
      end
      HOLD, DONE: bus.SEL = LAST_PHASE;
      default:    bus.SEL = '0;
    endcase
  end

`ifdef DFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame count, wraps naturally at 16 bits
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset)              frame_cnt_q <= '0;
    else if (state == DONE)  frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dft32_seq_ctrl.sv
// Self-checking bench for dft32_seq_ctrl: a default-parameter instance (A)
// and a SETTLE_CYCLES=0 / HOLD_CYCLES=1 instance (B), each with a capture
// and frame_done scoreboard.
module tb_dft32_seq_ctrl;

  localparam int SA = 1;
  localparam int HA = 5;
  localparam int SB = 0;
  localparam int HB = 1;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  dft32_seq_ctrl_if ia();
  dft32_seq_ctrl_if ib();

  dft32_seq_ctrl #(.SETTLE_CYCLES(SA), .HOLD_CYCLES(HA), .CNT_W(4)) dut_a (
    .clk_100 (clk),
    .reset   (rst_a),
    .bus     (ia.master)
  );

  dft32_seq_ctrl #(.SETTLE_CYCLES(SB), .HOLD_CYCLES(HB), .CNT_W(4)) dut_b (
    .clk_100 (clk),
    .reset   (rst_b),
    .bus     (ib.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [1:0] sel;
    logic [3:0] en;
  } cap_t;

  cap_t qa[$];
  cap_t qb[$];
  int   qa_done[$];
  int   qb_done[$];

  int cyc       = 0;
  int tests_run = 0;
  int fails     = 0;

  // Expected capture strobes and frame_done edge for a frame accepted at edge acc
  function automatic void push_a(input int acc);
    cap_t c;
    for (int p = 0; p < 4; p++) begin
      c.edge_n = acc + (p + 1) * (SA + 1);
      c.sel    = 2'(p);
      c.en     = 4'(1 << p);
      qa.push_back(c);
    end
    qa_done.push_back(acc + 4 * (SA + 1) + HA + 1);
  endfunction

  function automatic void push_b(input int acc);
    cap_t c;
    for (int p = 0; p < 4; p++) begin
      c.edge_n = acc + (p + 1) * (SB + 1);
      c.sel    = 2'(p);
      c.en     = 4'(1 << p);
      qb.push_back(c);
    end
    qb_done.push_back(acc + 4 * (SB + 1) + HB + 1);
  endfunction

  // One clock; at the falling edge compare whatever the DUTs present for the
  // upcoming rising edge (edge number cyc+1) against the scoreboards.
  task automatic tick();
    cap_t c;
    int   e;
    int   d;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e = cyc + 1;
    if (ia.enable !== 4'b0000) begin
      tests_run++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_enable edge=%0d got=%b required=0000", e, ia.enable);
      end else begin
        c = qa.pop_front();
        if (e !== c.edge_n || ia.enable !== c.en || ia.SEL !== c.sel) begin
          fails++;
          $display("FAIL a_capture got edge=%0d en=%b sel=%0d required edge=%0d en=%b sel=%0d",
                   e, ia.enable, ia.SEL, c.edge_n, c.en, c.sel);
        end
      end
    end
    if (ia.frame_done !== 1'b0) begin
      tests_run++;
      if (qa_done.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_done edge=%0d got=%b required=0", e, ia.frame_done);
      end else begin
        d = qa_done.pop_front();
        if (e !== d) begin
          fails++;
          $display("FAIL a_done_edge got=%0d required=%0d", e, d);
        end
      end
    end
    if (ib.enable !== 4'b0000) begin
      tests_run++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_enable edge=%0d got=%b required=0000", e, ib.enable);
      end else begin
        c = qb.pop_front();
        if (e !== c.edge_n || ib.enable !== c.en || ib.SEL !== c.sel) begin
          fails++;
          $display("FAIL b_capture got edge=%0d en=%b sel=%0d required edge=%0d en=%b sel=%0d",
                   e, ib.enable, ib.SEL, c.edge_n, c.en, c.sel);
        end
      end
    end
    if (ib.frame_done !== 1'b0) begin
      tests_run++;
      if (qb_done.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_done edge=%0d got=%b required=0", e, ib.frame_done);
      end else begin
        d = qb_done.pop_front();
        if (e !== d) begin
          fails++;
          $display("FAIL b_done_edge got=%0d required=%0d", e, d);
        end
      end
    end
  endtask

  // Bounded wait for all expected events, then require empty scoreboards
  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() + qb.size() + qa_done.size() + qb_done.size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    tests_run++;
    if ((qa.size() + qb.size() + qa_done.size() + qb_done.size()) != 0) begin
      fails++;
      $display("FAIL %s_drain pending=%0d required=0", name,
               qa.size() + qb.size() + qa_done.size() + qb_done.size());
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    #12;
    tests_run++;
    if ({ia.in_ready, ia.busy, ia.SEL, ia.enable, ia.frame_done} !== 9'b1_0_00_0000_0) begin
      fails++;
      $display("FAIL reset_a_outputs got=%b required=100000000",
               {ia.in_ready, ia.busy, ia.SEL, ia.enable, ia.frame_done});
    end
    tests_run++;
    if ({ib.in_ready, ib.busy, ib.SEL, ib.enable, ib.frame_done} !== 9'b1_0_00_0000_0) begin
      fails++;
      $display("FAIL reset_b_outputs got=%b required=100000000",
               {ib.in_ready, ib.busy, ib.SEL, ib.enable, ib.frame_done});
    end
    tick();
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tests_run++;
    if ({ia.in_ready, ia.busy, ib.in_ready, ib.busy} !== 4'b1010) begin
      fails++;
      $display("FAIL released_idle got=%b required=1010",
               {ia.in_ready, ia.busy, ib.in_ready, ib.busy});
    end
  endtask

  task automatic test_single_frame();
    int  acc;
    int  e;
    logic exp_busy;
    ia.in_valid = 1'b1;
    acc = cyc + 1;
    push_a(acc);
    tick();
    ia.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = cyc + 1;
      exp_busy = (e >= acc + 1) && (e <= acc + 14);
      tests_run++;
      if ({ia.busy, ia.in_ready} !== {exp_busy, ~exp_busy}) begin
        fails++;
        $display("FAIL single_busy edge=%0d got busy/ready=%b required=%b",
                 e - acc, {ia.busy, ia.in_ready}, {exp_busy, ~exp_busy});
      end
      tick();
    end
    drain("single");
  endtask

  task automatic test_fast_params();
    ib.in_valid = 1'b1;
    push_b(cyc + 1);
    tick();
    ib.in_valid = 1'b0;
    drain("fast");
  endtask

  task automatic test_back_to_back();
    int acc;
    int e;
    int pulses = 0;
    ia.in_valid = 1'b1;
    acc = cyc + 1;
    push_a(acc);
    push_a(acc + 15);
    for (int k = 0; k < 30; k++) begin
      e = cyc + 1;
      if (e == acc + 14) begin
        tests_run++;
        if (ia.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_in_done got=%b required=0", ia.in_ready);
        end
      end
      if (e == acc + 15) begin
        tests_run++;
        if (ia.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready_idle got=%b required=1", ia.in_ready);
        end
      end
      tick();
      if (ia.enable !== 4'b0000) pulses++;
    end
    ia.in_valid = 1'b0;
    tests_run++;
    if (pulses !== 8) begin
      fails++;
      $display("FAIL b2b_pulse_count got=%0d required=8", pulses);
    end
    drain("b2b");
  endtask

  task automatic test_ignore_valid();
    int acc;
    int e;
    ia.in_valid = 1'b1;
    acc = cyc + 1;
    push_a(acc);
    tick();
    for (int k = 0; k < 15; k++) begin
      e = cyc + 1;
      ia.in_valid = (e == acc + 2) || (e == acc + 10);
      if (ia.in_valid) begin
        tests_run++;
        if (ia.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL ignore_ready edge=%0d got=%b required=0", e - acc, ia.in_ready);
        end
      end
      tick();
    end
    ia.in_valid = 1'b0;
    tests_run++;
    if (ia.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ignore_back_idle got=%b required=1", ia.in_ready);
    end
    drain("ignore");
  endtask

  task automatic test_mid_reset();
    ia.in_valid = 1'b1;
    push_a(cyc + 1);
    tick();
    ia.in_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (ia.SEL !== 2'd2) begin
      fails++;
      $display("FAIL midrst_phase got=%0d required=2", ia.SEL);
    end
    rst_a = 1'b0;
    #1;
    tests_run++;
    if ({ia.in_ready, ia.busy, ia.SEL, ia.enable, ia.frame_done} !== 9'b1_0_00_0000_0) begin
      fails++;
      $display("FAIL midrst_async got=%b required=100000000",
               {ia.in_ready, ia.busy, ia.SEL, ia.enable, ia.frame_done});
    end
    qa.delete();
    qa_done.delete();
    repeat (3) tick();
    rst_a = 1'b1;
    repeat (16) tick();
    ia.in_valid = 1'b1;
    push_a(cyc + 1);
    tick();
    ia.in_valid = 1'b0;
    drain("midrst");
  endtask

`ifdef DFT_SEQ_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst_a = 1'b0;
    #1;
    tests_run++;
    if (ia.frame_cnt !== 16'd0) begin
      fails++;
      $display("FAIL frame_cnt_reset got=%0d required=0", ia.frame_cnt);
    end
    tick();
    rst_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      ia.in_valid = 1'b1;
      push_a(cyc + 1);
      tick();
      ia.in_valid = 1'b0;
      drain("frame_cnt");
      tick();
    end
    tests_run++;
    if (ia.frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL frame_cnt_count got=%0d required=3", ia.frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_fast_params();
    test_back_to_back();
    test_ignore_valid();
    test_mid_reset();
`ifdef DFT_SEQ_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cycles=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
